dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_byte_array.sv | 56 +++++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  // Responder sequencing: accept in IDLE, count down in WAIT, answer in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Legal transfer sizes in bytes.
  localparam logic [3:0] XFER_1 = 4'd1;
  localparam logic [3:0] XFER_2 = 4'd2;
  localparam logic [3:0] XFER_4 = 4'd4;
  localparam logic [3:0] XFER_8 = 4'd8;

  localparam int DEF_DEPTH_BYTES = 1024;
  localparam int DEF_LATENCY     = 2;
  localparam int CNT_W           = 4;

  function automatic logic size_legal(input logic [3:0] s);
    return (s == XFER_1) || (s == XFER_2) || (s == XFER_4) || (s == XFER_8);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a requester and the dmem responder.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready handshake; the response is an unthrottled one-cycle pulse.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] address;
  logic        read_enable;
  logic        write_enable;
  logic [3:0]  xfer_size;
  logic [63:0] write_data;
  logic        resp_valid;
  logic [63:0] read_data;
  logic        err;

  modport master (
    output req_valid, address, read_enable, write_enable, xfer_size, write_data,
    input  req_ready, resp_valid, read_data, err
  );

  modport slave (
    input  req_valid, address, read_enable, write_enable, xfer_size, write_data,
    output req_ready, resp_valid, read_data, err
  );
endinterface

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage with big-endian lane insert/extract for 1..8 byte transfers.
// Latency: write commits on the clock edge; read is combinational.
// Backpressure: none; the caller only enables writes for legal, in-range accesses.
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH_BYTES = DEF_DEPTH_BYTES,
  localparam int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [3:0]    wr_size_i,
  input  logic [63:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic [3:0]    rd_size_i,
  output logic [63:0]   rd_data_o
);

  // Storage deliberately has no reset: contents survive reset.
  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [7:0]    wr_lane_en;
  logic [AW-1:0] wr_idx [8];
  logic [63:0]   wr_msb;
  logic [63:0]   rd_msb;
  logic [6:0]    wr_sh;
  logic [6:0]    rd_sh;

  // Left-justify store data so lane i (byte at addr+i) is always the byte at bits 63-8i.
  always_comb begin
    wr_sh  = {4'd8 - wr_size_i, 3'b000};
    wr_msb = wr_data_i << wr_sh;
    for (int i = 0; i < 8; i++) begin
      wr_lane_en[i] = wr_en_i && (4'(i) < wr_size_i);
      wr_idx[i]     = wr_addr_i + AW'(i);
    end
  end

  // Commit each enabled lane to its byte address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wr_lane_en[i]) mem_q[wr_idx[i]] <= wr_msb[63-8*i -: 8];
    end
  end

  // Gather bytes left-justified, then right-justify; unused lanes stay zero.
  always_comb begin
    rd_msb = '0;
    rd_sh  = {4'd8 - rd_size_i, 3'b000};
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < rd_size_i) rd_msb[63-8*i -: 8] = mem_q[rd_addr_i + AW'(i)];
    end
    rd_data_o = rd_msb >> rd_sh;
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder; macro DMEM_RESPONDER_ALIGN_CHECK_EN makes misaligned accesses errors.
// Latency: response pulse LATENCY cycles after acceptance; stores commit on the edge ending RESP.
// Backpressure: req_ready high only in IDLE, so one request is in flight at a time.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic clk,
  input  logic reset,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_BYTES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q;
  logic             we_q;
  logic [3:0]       size_q;
  logic [63:0]      wdata_q;
  logic             err_q;

  logic             accept;
  logic             req_err;
  logic [64:0]      end_addr;
  logic             mem_wr_en;
  logic [63:0]      mem_rd_data;

  assign accept = bus.req_valid && (state_q == IDLE);

  // Classify the presented request; only consulted on acceptance.
  always_comb begin
    end_addr = {1'b0, bus.address} + {61'd0, bus.xfer_size};
    req_err  = (bus.read_enable == bus.write_enable) ||
               !size_legal(bus.xfer_size) ||
               (end_addr > 65'(DEPTH_BYTES));
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    if ((bus.address[3:0] & (bus.xfer_size - 4'd1)) != 4'd0) req_err = 1'b1;
`else
`endif
  end

  // State and countdown registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on acceptance so later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.address[AW-1:0];
      we_q    <= bus.write_enable;
      size_q  <= bus.xfer_size;
      wdata_q <= bus.write_data;
      err_q   <= req_err;
    end
  end

  // Next state: WAIT runs LATENCY-1 cycles, leaving when the counter hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; erroring or store responses return zero data.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.err        = (state_q == RESP) && err_q;
    bus.read_data  = ((state_q == RESP) && !err_q && !we_q) ? mem_rd_data : '0;
    mem_wr_en      = (state_q == RESP) && we_q && !err_q;
  end

  dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
    .clk       (clk),
    .wr_en_i   (mem_wr_en),
    .wr_addr_i (addr_q),
    .wr_size_i (size_q),
    .wr_data_i (wdata_q),
    .rd_addr_i (addr_q),
    .rd_size_i (size_q),
    .rd_data_o (mem_rd_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_BYTES=1024, LATENCY=2).
// Latency: expects the response pulse 2 cycles after acceptance.
// Backpressure: exercises req_ready holding off back-to-back requests.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from IDLE (called at posedge+1), wait for its response, return idle.
  task automatic do_req(input logic [63:0] a, input logic r, input logic w,
                        input logic [3:0] s, input logic [63:0] wd,
                        output logic [63:0] rdat, output logic e, output int lat);
    bus.req_valid    = 1'b1;
    bus.address      = a;
    bus.read_enable  = r;
    bus.write_enable = w;
    bus.xfer_size    = s;
    bus.write_data   = wd;
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
    bus.address      = {$urandom, $urandom};
    bus.write_data   = {$urandom, $urandom};
    bus.xfer_size    = 4'($urandom);
    bus.read_enable  = 1'($urandom);
    bus.write_enable = 1'($urandom);
    lat  = -1;
    rdat = '0;
    e    = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.resp_valid === 1'b1) begin
        lat  = k;
        rdat = bus.read_data;
        e    = bus.err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b1; bus.address = 64'd16; bus.read_enable = 1'b1;
    bus.write_enable = 1'b0; bus.xfer_size = 4'd8; bus.write_data = '0;
    #12;
    n_chk++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", bus.req_ready); else n_pass++;
    n_chk++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", bus.resp_valid); else n_pass++;
    n_chk++; if (bus.err !== 1'b0) $display("FAIL rst_err got %b want 0", bus.err); else n_pass++;
    n_chk++; if (bus.read_data !== 64'd0) $display("FAIL rst_read_data got %h want 0", bus.read_data); else n_pass++;
    bus.req_valid = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [63:0] d; logic e; int lat;
    do_req(64'd16, 1'b0, 1'b1, 4'd8, 64'h0123456789ABCDEF, d, e, lat);
    n_chk++; if (lat !== LAT) $display("FAIL st_latency got %0d want %0d", lat, LAT); else n_pass++;
    n_chk++; if (e !== 1'b0) $display("FAIL st_err got %b want 0", e); else n_pass++;
    do_req(64'd16, 1'b1, 1'b0, 4'd8, 64'd0, d, e, lat);
    n_chk++; if (lat !== LAT) $display("FAIL ld_latency got %0d want %0d", lat, LAT); else n_pass++;
    n_chk++; if (e !== 1'b0) $display("FAIL ld_err got %b want 0", e); else n_pass++;
    n_chk++; if (d !== 64'h0123456789ABCDEF) $display("FAIL ld_data got %h want 0123456789abcdef", d); else n_pass++;
  endtask

  task automatic test_sub_word();
    logic [63:0] d; logic e; int lat;
    do_req(64'd17, 1'b1, 1'b0, 4'd1, 64'd0, d, e, lat);
    n_chk++; if (d !== 64'h23 || e !== 1'b0) $display("FAIL byte17 got %h/%b want 23/0", d, e); else n_pass++;
    do_req(64'd16, 1'b1, 1'b0, 4'd2, 64'd0, d, e, lat);
    n_chk++; if (d !== 64'h0123) $display("FAIL half16 got %h want 0123", d); else n_pass++;
    do_req(64'd20, 1'b1, 1'b0, 4'd4, 64'd0, d, e, lat);
    n_chk++; if (d !== 64'h89ABCDEF) $display("FAIL word20 got %h want 89abcdef", d); else n_pass++;
    do_req(64'd22, 1'b1, 1'b0, 4'd2, 64'd0, d, e, lat);
    n_chk++; if (d !== 64'hCDEF) $display("FAIL half22 got %h want cdef", d); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [63:0] d; logic e; int lat;
    do_req(64'd0, 1'b0, 1'b1, 4'd8, 64'h1122334455667788, d, e, lat);
    do_req(64'd1016, 1'b0, 1'b1, 4'd8, 64'd0, d, e, lat);
    n_chk++; if (e !== 1'b0) $display("FAIL edge_fit_err got %b want 0", e); else n_pass++;
    do_req(64'd1020, 1'b0, 1'b1, 4'd4, 64'hAABBCCDD, d, e, lat);
    do_req(64'd0, 1'b1, 1'b1, 4'd8, 64'hFFFFFFFFFFFFFFFF, d, e, lat);
    n_chk++; if (e !== 1'b1 || d !== 64'd0 || lat !== LAT) $display("FAIL both_en got err=%b data=%h lat=%0d want 1/0/%0d", e, d, lat, LAT); else n_pass++;
    do_req(64'd0, 1'b0, 1'b0, 4'd8, 64'hFFFFFFFFFFFFFFFF, d, e, lat);
    n_chk++; if (e !== 1'b1) $display("FAIL no_en got err=%b want 1", e); else n_pass++;
    do_req(64'd0, 1'b0, 1'b1, 4'd3, 64'hFFFFFF, d, e, lat);
    n_chk++; if (e !== 1'b1) $display("FAIL size3 got err=%b want 1", e); else n_pass++;
    do_req(64'd1020, 1'b0, 1'b1, 4'd8, 64'hFFFFFFFFFFFFFFFF, d, e, lat);
    n_chk++; if (e !== 1'b1) $display("FAIL past_end got err=%b want 1", e); else n_pass++;
    do_req(64'd1020, 1'b1, 1'b0, 4'd8, 64'd0, d, e, lat);
    n_chk++; if (e !== 1'b1 || d !== 64'd0) $display("FAIL past_end_ld got err=%b data=%h want 1/0", e, d); else n_pass++;
    do_req(64'd0, 1'b1, 1'b0, 4'd8, 64'd0, d, e, lat);
    n_chk++; if (d !== 64'h1122334455667788) $display("FAIL mem0_kept got %h want 1122334455667788", d); else n_pass++;
    do_req(64'd1016, 1'b1, 1'b0, 4'd8, 64'd0, d, e, lat);
    n_chk++; if (d !== 64'h00000000AABBCCDD) $display("FAIL mem1016_kept got %h want 00000000aabbccdd", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nacc, since, bad_ready, bad_data;
    int pulse_at[$];
    logic acc;
    nacc = 0; since = 0; bad_ready = 0; bad_data = 0;
    bus.req_valid = 1'b1; bus.read_enable = 1'b1; bus.write_enable = 1'b0;
    bus.xfer_size = 4'd8; bus.address = 64'd16; bus.write_data = '0;
    for (int c = 1; c <= 20; c++) begin
      acc = bus.req_valid && bus.req_ready;
      @(posedge clk); #1;
      if (acc) begin
        nacc++;
        since = 1;
        if (nacc == 3) bus.req_valid = 1'b0;
      end else if (since > 0) begin
        since++;
      end
      if (since >= 1 && since <= LAT && bus.req_ready !== 1'b0) bad_ready++;
      if (bus.resp_valid === 1'b1) begin
        pulse_at.push_back(c);
        if (bus.read_data !== 64'h0123456789ABCDEF) bad_data++;
      end
    end
    bus.req_valid = 1'b0;
    n_chk++; if (nacc !== 3) $display("FAIL b2b_accepts got %0d want 3", nacc); else n_pass++;
    n_chk++; if (pulse_at.size() !== 3) $display("FAIL b2b_pulses got %0d want 3", pulse_at.size()); else n_pass++;
    n_chk++; if (bad_ready !== 0) $display("FAIL b2b_ready_low got %0d busy cycles with ready high want 0", bad_ready); else n_pass++;
    n_chk++; if (bad_data !== 0) $display("FAIL b2b_data got %0d bad responses want 0", bad_data); else n_pass++;
    n_chk++;
    if (pulse_at.size() < 3) $display("FAIL b2b_spacing got %0d pulses want 3 spaced %0d", pulse_at.size(), LAT + 1);
    else if (pulse_at[1] - pulse_at[0] !== LAT + 1 || pulse_at[2] - pulse_at[1] !== LAT + 1)
      $display("FAIL b2b_spacing got %0d,%0d want %0d", pulse_at[1] - pulse_at[0], pulse_at[2] - pulse_at[1], LAT + 1);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [63:0] d; logic e; int lat; int saw;
    saw = 0;
    do_req(64'd8, 1'b0, 1'b1, 4'd8, 64'h0102030405060708, d, e, lat);
    bus.req_valid = 1'b1; bus.address = 64'd8; bus.read_enable = 1'b0;
    bus.write_enable = 1'b1; bus.xfer_size = 4'd8; bus.write_data = 64'hFF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_chk++; if (bus.req_ready !== 1'b0) $display("FAIL abort_in_wait got ready=%b want 0", bus.req_ready); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) $display("FAIL abort_rst_out got ready=%b resp=%b want 1/0", bus.req_ready, bus.resp_valid); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst_n = 1'b1;
      if (bus.resp_valid === 1'b1) saw++;
    end
    n_chk++; if (saw !== 0) $display("FAIL abort_no_resp got %0d pulses want 0", saw); else n_pass++;
    do_req(64'd8, 1'b1, 1'b0, 4'd8, 64'd0, d, e, lat);
    n_chk++; if (d !== 64'h0102030405060708) $display("FAIL abort_mem got %h want 0102030405060708", d); else n_pass++;
  endtask

  task automatic test_align();
    logic [63:0] d; logic e; int lat;
    do_req(64'd2, 1'b0, 1'b1, 4'd4, 64'hDEADBEEF, d, e, lat);
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    n_chk++; if (e !== 1'b1) $display("FAIL align_st_err got %b want 1", e); else n_pass++;
    do_req(64'd0, 1'b1, 1'b0, 4'd8, 64'd0, d, e, lat);
    n_chk++; if (d !== 64'h1122334455667788) $display("FAIL align_mem got %h want 1122334455667788", d); else n_pass++;
`else
    n_chk++; if (e !== 1'b0) $display("FAIL align_st_err got %b want 0", e); else n_pass++;
    do_req(64'd2, 1'b1, 1'b0, 4'd4, 64'd0, d, e, lat);
    n_chk++; if (d !== 64'hDEADBEEF || e !== 1'b0) $display("FAIL align_ld got %h/%b want deadbeef/0", d, e); else n_pass++;
    do_req(64'd0, 1'b1, 1'b0, 4'd8, 64'd0, d, e, lat);
    n_chk++; if (d !== 64'h1122DEADBEEF7788) $display("FAIL align_mem got %h want 1122deadbeef7788", d); else n_pass++;
`endif
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_store_load();
    test_sub_word();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    test_align();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
